i2s_rx_10xe: RTL and testbench

I2S receiver. It is the counterpart of the I2S transmitter and is used both as a loopback checker and as a capture path. The block oversamples external SCLK/LRCLK/SDATA in the system clock domain, deserializes each channel slot, and emits samples on a 32-bit AXI-Stream master. TID carries the channel; a small FIFO absorbs downstream backpressure.

---
 rtl/i2s_rx_10xe.sv | 195 +++++++++++++++++++
 tb/tb_i2s_rx_10xe.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_10xe.sv
// I2S receiver: oversamples SCLK/LRCLK/SDATA, deserializes each slot and emits
// MSB-aligned samples on AXI-Stream through a small FWFT FIFO. Optional macro: I2S_RX_WORD_CNT_EN.
module i2s_rx_10xe #(
  parameter int AXI_STREAM_DATA_WIDTH = 32,
  parameter int AXI_STREAM_TID_WIDTH  = 3,
  parameter int SAMPLE_WIDTH          = 24,
  parameter int FIFO_DEPTH            = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rx_en,
  input  logic                             sclk_in,
  input  logic                             lrclk_in,
  input  logic                             sdata_in,
  output logic [AXI_STREAM_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXI_STREAM_TID_WIDTH-1:0]  m_axis_tid,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             overflow_o,
  input  logic                             overflow_clr,
`ifdef I2S_RX_WORD_CNT_EN
  output logic [31:0]                      word_cnt_o,
`endif
  output logic                             busy_o
);

  localparam int DW  = AXI_STREAM_DATA_WIDTH;
  localparam int TW  = AXI_STREAM_TID_WIDTH;
  localparam int SW  = SAMPLE_WIDTH;
  localparam int CW  = $clog2(SW + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = DW + TW;
  localparam int PAD = DW - SW;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Handshake: a beat transfers on a clk edge where m_axis_tvalid && m_axis_tready;
  // once raised, tvalid/tdata/tid hold until that transfer (only rst can drop them).

  logic sclk_meta, sclk_sync, sclk_prev;
  logic lrclk_meta, lrclk_sync;
  logic sdata_meta, sdata_sync;
  logic ws_prev;
  logic strobe;

  state_t        state_q, state_d;
  logic [SW-1:0] shift_q, shift_d, shift_ins, fin_word, aligned;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc, fin_cnt;
  logic          commit;
  logic [DW-1:0] commit_data;
  logic [TW-1:0] commit_tid;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;
  logic          full, empty, push_ok, pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_meta  <= 1'b0;
      sclk_sync  <= 1'b0;
      sclk_prev  <= 1'b0;
      lrclk_meta <= 1'b0;
      lrclk_sync <= 1'b0;
      sdata_meta <= 1'b0;
      sdata_sync <= 1'b0;
      ws_prev    <= 1'b0;
    end else begin
      sclk_meta  <= sclk_in;
      sclk_sync  <= sclk_meta;
      sclk_prev  <= sclk_sync;
      lrclk_meta <= lrclk_in;
      lrclk_sync <= lrclk_meta;
      sdata_meta <= sdata_in;
      sdata_sync <= sdata_meta;
      if (strobe) ws_prev <= lrclk_sync;
    end
  end

  assign strobe = sclk_sync & ~sclk_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign shift_ins = {shift_q[SW-2:0], sdata_sync};
  assign cnt_inc   = cnt_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    commit     = 1'b0;
    fin_word   = '0;
    fin_cnt    = '0;
    case (state_q)
      IDLE: begin
        if (rx_en && strobe && (lrclk_sync != ws_prev)) begin
          state_d = RECV;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      RECV: begin
        if (!rx_en) begin
          state_d = IDLE;
          shift_d = '0;
          cnt_d   = '0;
        end else if (strobe) begin
          if (lrclk_sync == ws_prev) begin
            if (cnt_q < CW'(SW)) begin
              shift_d = shift_ins;
              cnt_d   = cnt_inc;
            end
          end else begin
            // WS changed: this bit is the LSB of the slot that just ended.
            commit = 1'b1;
            if (cnt_q < CW'(SW)) begin
              fin_word = shift_ins;
              fin_cnt  = cnt_inc;
            end else begin
              fin_word = shift_q;
              fin_cnt  = cnt_q;
            end
            shift_d = '0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Short slots leave their missing LSBs as zero after left alignment.
  assign aligned     = fin_word << (CW'(SW) - fin_cnt);
  assign commit_data = DW'(aligned) << PAD;
  assign commit_tid  = TW'(ws_prev);

  assign full    = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = commit && !full;
  assign pop     = !empty && m_axis_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {commit_tid, commit_data};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      // Fullness is judged before this cycle's pop, so a new overflow beats a clear.
      if (commit && full) overflow_o <= 1'b1;
      else if (overflow_clr) overflow_o <= 1'b0;
    end
  end

  assign m_axis_tdata  = mem[rd_ptr][DW-1:0];
  assign m_axis_tid    = mem[rd_ptr][EW-1:DW];
  assign m_axis_tvalid = !empty;
  assign busy_o        = (state_q == RECV);

`ifdef I2S_RX_WORD_CNT_EN
  logic [31:0] word_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) word_cnt_q <= '0;
    else if (push_ok) word_cnt_q <= word_cnt_q + 32'd1;
  end

  assign word_cnt_o = word_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_rx_10xe.sv
// Directed bench for i2s_rx_10xe: drives I2S frames, records AXI-Stream beats
// and compares them with hand-computed samples.
module tb_i2s_rx_10xe;

  logic        clk;
  logic        rst;
  logic        rx_en;
  logic        sclk_in;
  logic        lrclk_in;
  logic        sdata_in;
  logic [31:0] m_axis_tdata;
  logic [2:0]  m_axis_tid;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        overflow_o;
  logic        overflow_clr;
  logic        busy_o;
`ifdef I2S_RX_WORD_CNT_EN
  logic [31:0] word_cnt_o;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [34:0] got_q[$];
  logic [34:0] exp_q[$];

  i2s_rx_10xe #(
    .AXI_STREAM_DATA_WIDTH(32),
    .AXI_STREAM_TID_WIDTH(3),
    .SAMPLE_WIDTH(24),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_en(rx_en),
    .sclk_in(sclk_in),
    .lrclk_in(lrclk_in),
    .sdata_in(sdata_in),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tid(m_axis_tid),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .overflow_o(overflow_o),
    .overflow_clr(overflow_clr),
`ifdef I2S_RX_WORD_CNT_EN
    .word_cnt_o(word_cnt_o),
`endif
    .busy_o(busy_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // beat recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready)
      got_q.push_back({m_axis_tid, m_axis_tdata});
  end

  // driver tasks
  task automatic realign();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic ws, input logic d);
    sclk_in  = 1'b0;
    lrclk_in = ws;
    sdata_in = d;
    #40;
    sclk_in  = 1'b1;
    #40;
  endtask

  // MSB..bit1 with lrclk=ch, LSB with lrclk=nxt (one-bit I2S delay)
  task automatic send_slot(input logic ch, input logic nxt, input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 1; i--) send_bit(ch, val[i]);
    send_bit(nxt, val[0]);
  endtask

  // discarded partial slot on !ch, then the WS edge that starts channel ch
  task automatic begin_stream(input logic ch);
    rx_en = 1'b0;
    send_bit(!ch, 1'b0);
    rx_en = 1'b1;
    repeat (3) send_bit(!ch, 1'b1);
    send_bit(ch, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #23;
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tid, overflow_o, busy_o} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got tvalid=%b tdata=%h tid=%h ovf=%b busy=%b required all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tid, overflow_o, busy_o);
    end
    realign();
    rst = 1'b0;
    m_axis_tready = 1'b0;
    begin_stream(1'b0);
    send_slot(1'b0, 1'b1, 32'h111111, 24);
    send_slot(1'b1, 1'b0, 32'h222222, 24);
    repeat (10) send_bit(1'b0, 1'b1);
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prestate: got tvalid=%b busy=%b required 1 1", m_axis_tvalid, busy_o);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tid, overflow_o, busy_o} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_midstream: got tvalid=%b tdata=%h tid=%h ovf=%b busy=%b required all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tid, overflow_o, busy_o);
    end
    #20;
    realign();
    rst = 1'b0;
    repeat (13) send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_partial: got tvalid=%b required 0", m_axis_tvalid);
    end
    send_slot(1'b1, 1'b0, 32'h333333, 24);
    rx_en = 1'b0;
    got_q.delete();
    exp_q.delete();
    exp_q.push_back({3'd1, 32'h33333300});
    realign();
    m_axis_tready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (got_q.size() >= exp_q.size()) break;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL reset_beat_count: got %0d beats required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] left;
    left = 32'hA5A5A5;
    realign();
    got_q.delete();
    exp_q.delete();
    m_axis_tready = 1'b1;
    begin_stream(1'b0);
    for (int i = 23; i >= 1; i--) send_bit(1'b0, left[i]);
    realign();
    sclk_in  = 1'b0;
    lrclk_in = 1'b1;
    sdata_in = left[0];
    #40;
    sclk_in = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency_early: got tvalid=%b required 0", m_axis_tvalid);
    end
    @(negedge clk);
    n_cmp++;
    if (m_axis_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: got tvalid=%b required 1", m_axis_tvalid);
    end
    #7;
    send_slot(1'b1, 1'b0, 32'h123456, 24);
    rx_en = 1'b0;
    exp_q.push_back({3'd0, 32'hA5A5A500});
    exp_q.push_back({3'd1, 32'h12345600});
    for (int k = 0; k < 300; k++) begin
      if (got_q.size() >= exp_q.size()) break;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL basic_beat_count: got %0d beats required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_short_long();
    realign();
    got_q.delete();
    exp_q.delete();
    m_axis_tready = 1'b1;
    begin_stream(1'b0);
    send_slot(1'b0, 1'b1, 32'h0000FFFF, 16);
    send_slot(1'b1, 1'b0, 32'hDEADBEEF, 32);
    rx_en = 1'b0;
    exp_q.push_back({3'd0, 32'hFFFF0000});
    exp_q.push_back({3'd1, 32'hDEADBE00});
    for (int k = 0; k < 300; k++) begin
      if (got_q.size() >= exp_q.size()) break;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL slot_beat_count: got %0d beats required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL slot_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    realign();
    got_q.delete();
    exp_q.delete();
    m_axis_tready = 1'b0;
    begin_stream(1'b0);
    send_slot(1'b0, 1'b1, 32'h100001, 24);
    send_slot(1'b1, 1'b0, 32'h200002, 24);
    send_slot(1'b0, 1'b1, 32'h300003, 24);
    send_slot(1'b1, 1'b0, 32'h400004, 24);
    n_cmp++;
    if (overflow_o !== 1'b0 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h10000100) begin
      n_fail++;
      $display("FAIL bp_full: got ovf=%b tvalid=%b tdata=%h required 0 1 10000100",
               overflow_o, m_axis_tvalid, m_axis_tdata);
    end
    send_slot(1'b0, 1'b1, 32'h500005, 24);
    n_cmp++;
    if (overflow_o !== 1'b1 || m_axis_tdata !== 32'h10000100 || m_axis_tid !== 3'd0) begin
      n_fail++;
      $display("FAIL bp_overflow: got ovf=%b tdata=%h tid=%h required 1 10000100 0",
               overflow_o, m_axis_tdata, m_axis_tid);
    end
    rx_en = 1'b0;
    realign();
    overflow_clr = 1'b1;
    realign();
    overflow_clr = 1'b0;
    n_cmp++;
    if (overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_clear: got ovf=%b required 0", overflow_o);
    end
    exp_q.push_back({3'd0, 32'h10000100});
    exp_q.push_back({3'd1, 32'h20000200});
    exp_q.push_back({3'd0, 32'h30000300});
    exp_q.push_back({3'd1, 32'h40000400});
    m_axis_tready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (got_q.size() >= exp_q.size()) break;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (got_q.size() != exp_q.size() || m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_beat_count: got %0d beats tvalid=%b required %0d 0",
               got_q.size(), m_axis_tvalid, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_disable();
    realign();
    got_q.delete();
    exp_q.delete();
    m_axis_tready = 1'b0;
    begin_stream(1'b0);
    send_slot(1'b0, 1'b1, 32'hABCDEF, 24);
    repeat (12) send_bit(1'b1, 1'b1);
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL dis_busy_before: got busy=%b required 1", busy_o);
    end
    rx_en = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL dis_busy_after: got busy=%b required 0", busy_o);
    end
    realign();
    repeat (11) send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    exp_q.push_back({3'd0, 32'hABCDEF00});
    realign();
    m_axis_tready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (got_q.size() >= exp_q.size()) break;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL dis_beat_count: got %0d beats required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL dis_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

`ifdef I2S_RX_WORD_CNT_EN
  task automatic test_word_cnt();
    realign();
    rst = 1'b1;
    realign();
    rst = 1'b0;
    m_axis_tready = 1'b0;
    n_cmp++;
    if (word_cnt_o !== 32'd0) begin
      n_fail++;
      $display("FAIL wc_reset: got %h required 0", word_cnt_o);
    end
    begin_stream(1'b0);
    for (int i = 0; i < 10; i++) begin
      send_slot(i[0], !i[0], 32'h0A0000 + i, 24);
      if (i == 4) begin
        realign();
        m_axis_tready = 1'b1;
      end
    end
    n_cmp++;
    if (word_cnt_o !== 32'd9) begin
      n_fail++;
      $display("FAIL wc_count: got %0d required 9", word_cnt_o);
    end
    force dut.word_cnt_q = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    release dut.word_cnt_q;
    send_slot(1'b0, 1'b1, 32'h0B0B0B, 24);
    n_cmp++;
    if (word_cnt_o !== 32'd0) begin
      n_fail++;
      $display("FAIL wc_wrap: got %h required 0", word_cnt_o);
    end
    rx_en = 1'b0;
    repeat (20) @(negedge clk);
  endtask
`endif

  initial begin
    rst           = 1'b1;
    rx_en         = 1'b0;
    sclk_in       = 1'b0;
    lrclk_in      = 1'b0;
    sdata_in      = 1'b0;
    m_axis_tready = 1'b1;
    overflow_clr  = 1'b0;
    test_reset();
    test_basic();
    test_short_long();
    test_backpressure();
    test_disable();
`ifdef I2S_RX_WORD_CNT_EN
    test_word_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
